// File: rtl/dcache_ctrl.sv
// Direct-mapped data-cache controller: hit service, dirty-victim writeback,
// 4-word line fill from banked memory, then replay of the missed access.
module dcache_ctrl #(
   parameter int unsigned MEM_LAT         = 2,
   parameter bit          ERR_ON_MISALIGN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Rd,
   input  logic        Wr,
   input  logic [15:0] Addr,
   input  logic [15:0] DataIn,
   output logic [15:0] DataOut,
   output logic        Done,
   output logic        Stall,
   output logic        CacheHit,
   output logic        err,
   output logic        c_enable,
   output logic        c_comp,
   output logic        c_write,
   output logic        c_valid_in,
   output logic [7:0]  c_index,
   output logic [2:0]  c_offset,
   output logic [4:0]  c_tag_in,
   output logic [15:0] c_data_in,
   input  logic        c_hit,
   input  logic        c_dirty,
   input  logic        c_valid,
   input  logic [4:0]  c_tag_out,
   input  logic [15:0] c_data_out,
   output logic [15:0] m_addr,
   output logic [15:0] m_data_in,
   output logic        m_wr,
   output logic        m_rd,
   input  logic [15:0] m_data_out,
   input  logic        m_stall
);

   typedef enum logic [3:0] {
      IDLE, WB0, WB1, WB2, WB3, RD0, RD1, RD2, RD3, WT0, WT1, ACC
   } state_t;

   state_t state, next;

   logic [15:0]        addr_l;
   logic [15:0]        data_l;
   logic               wr_l;
   logic [MEM_LAT-1:0] rq;
   logic [1:0]         fill_cnt;
   logic               latch;
   logic               fill_wr;
   logic               illegal;
   logic [1:0]         k;
   logic [4:0]         tag_l;
   logic [7:0]         idx_l;

   assign tag_l   = addr_l[15:11];
   assign idx_l   = addr_l[10:3];
   assign illegal = (Rd & Wr) | (ERR_ON_MISALIGN & Addr[0]);
   // Fill word position follows returned data, not state, so stalls never skew it.
   assign fill_wr = rq[MEM_LAT-1];

   always_comb begin
      case (state)
         WB1, RD1: k = 2'd1;
         WB2, RD2: k = 2'd2;
         WB3, RD3: k = 2'd3;
         default:  k = 2'd0;
      endcase
   end

   always_comb begin
      next       = state;
      latch      = 1'b0;
      DataOut    = '0;
      Done       = 1'b0;
      Stall      = 1'b0;
      CacheHit   = 1'b0;
      err        = 1'b0;
      c_enable   = 1'b0;
      c_comp     = 1'b0;
      c_write    = 1'b0;
      c_valid_in = 1'b0;
      c_index    = '0;
      c_offset   = '0;
      c_tag_in   = '0;
      c_data_in  = '0;
      m_addr     = '0;
      m_data_in  = '0;
      m_wr       = 1'b0;
      m_rd       = 1'b0;
      if (rst) begin
         case (state)
            IDLE: begin
               if (Rd | Wr) begin
                  if (illegal) begin
                     err = 1'b1;
                  end else begin
                     c_enable  = 1'b1;
                     c_comp    = 1'b1;
                     c_write   = Wr;
                     c_index   = Addr[10:3];
                     c_offset  = Addr[2:0];
                     c_tag_in  = Addr[15:11];
                     c_data_in = DataIn;
                     if (c_hit & c_valid) begin
                        Done     = 1'b1;
                        CacheHit = 1'b1;
                        DataOut  = c_data_out;
                     end else begin
                        latch = 1'b1;
                        next  = (c_valid & c_dirty) ? WB0 : RD0;
                     end
                  end
               end
            end
            WB0, WB1, WB2, WB3: begin
               Stall     = 1'b1;
               c_enable  = 1'b1;
               c_index   = idx_l;
               c_offset  = {k, 1'b0};
               m_addr    = {c_tag_out, idx_l, k, 1'b0};
               m_data_in = c_data_out;
               if (!m_stall) begin
                  m_wr = 1'b1;
                  next = state_t'(state + 4'd1);
               end
            end
            RD0, RD1, RD2, RD3: begin
               Stall  = 1'b1;
               m_addr = {tag_l, idx_l, k, 1'b0};
               if (!m_stall) begin
                  m_rd = 1'b1;
                  next = state_t'(state + 4'd1);
               end
            end
            WT0: begin
               Stall = 1'b1;
               next  = WT1;
            end
            WT1: begin
               Stall = 1'b1;
               next  = ACC;
            end
            ACC: begin
               Stall     = 1'b1;
               c_enable  = 1'b1;
               c_comp    = 1'b1;
               c_write   = wr_l;
               c_index   = idx_l;
               c_offset  = addr_l[2:0];
               c_tag_in  = tag_l;
               c_data_in = data_l;
               Done      = 1'b1;
               DataOut   = c_data_out;
               next      = IDLE;
            end
            default: next = IDLE;
         endcase
         if (fill_wr) begin
            c_enable   = 1'b1;
            c_comp     = 1'b0;
            c_write    = 1'b1;
            c_valid_in = 1'b1;
            c_index    = idx_l;
            c_offset   = {fill_cnt, 1'b0};
            c_tag_in   = tag_l;
            c_data_in  = m_data_out;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         addr_l   <= '0;
         data_l   <= '0;
         wr_l     <= 1'b0;
         rq       <= '0;
         fill_cnt <= '0;
      end else begin
         state <= next;
         if (MEM_LAT > 1) rq <= {rq[MEM_LAT-2:0], m_rd};
         else             rq <= m_rd;
         if (latch) begin
            addr_l   <= Addr;
            data_l   <= DataIn;
            wr_l     <= Wr;
            fill_cnt <= '0;
         end else if (fill_wr) begin
            fill_cnt <= fill_cnt + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: behavioural cache array + banked memory environment and
// a line-level reference model that predicts hit/miss, traffic, latency and data.
module tb_dcache_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        Rd, Wr;
   logic [15:0] Addr, DataIn, DataOut;
   logic        Done, Stall, CacheHit, err;
   logic        c_enable, c_comp, c_write, c_valid_in;
   logic [7:0]  c_index;
   logic [2:0]  c_offset;
   logic [4:0]  c_tag_in;
   logic [15:0] c_data_in;
   logic        c_hit, c_dirty, c_valid;
   logic [4:0]  c_tag_out;
   logic [15:0] c_data_out;
   logic [15:0] m_addr, m_data_in;
   logic        m_wr, m_rd;
   logic [15:0] m_data_out;
   logic        m_stall;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dcache_ctrl #(.MEM_LAT(2), .ERR_ON_MISALIGN(1'b1)) dut (
      .clk(clk), .rst(rst), .Rd(Rd), .Wr(Wr), .Addr(Addr), .DataIn(DataIn),
      .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
      .c_enable(c_enable), .c_comp(c_comp), .c_write(c_write), .c_valid_in(c_valid_in),
      .c_index(c_index), .c_offset(c_offset), .c_tag_in(c_tag_in), .c_data_in(c_data_in),
      .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid), .c_tag_out(c_tag_out),
      .c_data_out(c_data_out), .m_addr(m_addr), .m_data_in(m_data_in), .m_wr(m_wr),
      .m_rd(m_rd), .m_data_out(m_data_out), .m_stall(m_stall)
   );

   // environment: cache array (valid cleared by reset) and 2-cycle memory
   logic [15:0] cdat [256][4];
   logic [4:0]  ctag [256];
   logic        cval [256];
   logic        cdir [256];
   logic [15:0] mem  [32768];
   logic [15:0] rd_pipe;

   assign c_valid    = cval[c_index];
   assign c_dirty    = cdir[c_index];
   assign c_tag_out  = ctag[c_index];
   assign c_data_out = cdat[c_index][c_offset[2:1]];
   assign c_hit      = c_enable & c_comp & cval[c_index] & (ctag[c_index] == c_tag_in);

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 256; i++) begin
            cval[i] <= 1'b0;
            cdir[i] <= 1'b0;
         end
      end else if (c_enable && c_write) begin
         if (c_comp) begin
            if (c_hit) begin
               cdat[c_index][c_offset[2:1]] <= c_data_in;
               cdir[c_index] <= 1'b1;
            end
         end else begin
            cdat[c_index][c_offset[2:1]] <= c_data_in;
            ctag[c_index] <= c_tag_in;
            cval[c_index] <= c_valid_in;
            cdir[c_index] <= 1'b0;
         end
      end
   end

   always @(posedge clk) begin
      if (m_wr) mem[m_addr[15:1]] <= m_data_in;
      rd_pipe    <= mem[m_addr[15:1]];
      m_data_out <= rd_pipe;
   end

   // reference model: backing memory image plus per-line cached copy
   logic [15:0] ref_mem  [32768];
   logic [15:0] ref_line [256][4];
   logic [4:0]  ref_tag  [256];
   logic        ref_val  [256];
   logic        ref_dir  [256];
   logic [15:0] wb_seen;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One access, checked every cycle. sk/slen: memory stall before request sk.
   // abort>=0 asserts reset mid-cycle at that cycle and checks all outputs are 0.
   task automatic access(input bit wr, input logic [15:0] a, input logic [15:0] d,
                         input int sk, input int slen, input int abort, output int done_at);
      logic [7:0]  idx;
      logic [4:0]  tag, vic_tag;
      logic [1:0]  w;
      logic [15:0] vic_line [4];
      logic [15:0] exp_val;
      bit          hit, dirty, ewr, erd;
      int          nreq, lat, ereq, rc;
      idx = a[10:3];
      tag = a[15:11];
      w   = a[2:1];
      hit   = ref_val[idx] && (ref_tag[idx] == tag);
      dirty = ref_val[idx] && ref_dir[idx] && !hit;
      nreq  = dirty ? 8 : 4;
      lat   = hit ? 0 : 1 + nreq + 2 + slen;
      vic_tag = ref_tag[idx];
      for (int j = 0; j < 4; j++) vic_line[j] = ref_line[idx][j];
      if (!hit) begin
         if (dirty)
            for (int j = 0; j < 4; j++) ref_mem[{vic_tag, idx, 2'(j)}] = vic_line[j];
         for (int j = 0; j < 4; j++) ref_line[idx][j] = ref_mem[{tag, idx, 2'(j)}];
         ref_tag[idx] = tag;
         ref_val[idx] = 1'b1;
         ref_dir[idx] = 1'b0;
      end
      exp_val = ref_line[idx][w];
      if (wr) begin
         ref_line[idx][w] = d;
         ref_dir[idx]     = 1'b1;
      end
      done_at = -1;
      for (int c = 0; c <= lat; c++) begin
         @(posedge clk);
         #1;
         if (c == 0) begin
            Rd = !wr; Wr = wr; Addr = a; DataIn = d;
         end
         m_stall = (slen > 0) && (c >= 1 + sk) && (c < 1 + sk + slen);
         if (c == abort) begin
            #2 rst = 1'b0;
            #1;
            chk1("rst_stall", Stall, 1'b0);
            chk1("rst_done", Done, 1'b0);
            chk1("rst_en", c_enable, 1'b0);
            chk1("rst_mrd", m_rd, 1'b0);
            chk1("rst_mwr", m_wr, 1'b0);
            chk1("rst_vin", c_valid_in, 1'b0);
            chk16("rst_maddr", m_addr, 16'h0000);
            return;
         end
         @(negedge clk);
         if (Done && done_at < 0) done_at = c;
         if (m_wr && m_addr == 16'h0012) wb_seen = m_data_in;
         chk1("stall", Stall, c != 0);
         chk1("done", Done, c == lat);
         chk1("cachehit", CacheHit, hit && c == 0);
         chk1("err", err, 1'b0);
         ereq = -1;
         for (int j = 0; j < nreq; j++) begin
            rc = 1 + j + ((slen > 0 && j >= sk) ? slen : 0);
            if (!hit && rc == c) ereq = j;
         end
         ewr = (ereq >= 0) && dirty && (ereq < 4);
         erd = (ereq >= 0) && !ewr;
         chk1("m_wr", m_wr, ewr);
         chk1("m_rd", m_rd, erd);
         if (ewr) begin
            chk16("wb_addr", m_addr, {vic_tag, idx, 2'(ereq), 1'b0});
            chk16("wb_data", m_data_in, vic_line[ereq]);
         end
         if (erd) chk16("rd_addr", m_addr, {tag, idx, 2'(ereq - (dirty ? 4 : 0)), 1'b0});
         if (c == lat && !wr) chk16("dataout", DataOut, exp_val);
      end
      @(posedge clk);
      #1;
      Rd = 1'b0; Wr = 1'b0; m_stall = 1'b0;
   endtask

   task automatic bad_req(input string name, input logic rd, input logic wr, input logic [15:0] a);
      @(posedge clk);
      #1;
      Rd = rd; Wr = wr; Addr = a; DataIn = 16'hFFFF;
      @(negedge clk);
      chk1({name, "_err"}, err, 1'b1);
      chk1({name, "_cen"}, c_enable, 1'b0);
      chk1({name, "_mrd"}, m_rd, 1'b0);
      chk1({name, "_mwr"}, m_wr, 1'b0);
      chk1({name, "_done"}, Done, 1'b0);
      @(posedge clk);
      #1;
      Rd = 1'b0; Wr = 1'b0;
      @(negedge clk);
      chk1({name, "_after_stall"}, Stall, 1'b0);
      chk1({name, "_after_err"}, err, 1'b0);
   endtask

   int lat;

   initial begin
      rst = 1'b0; Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0; m_stall = 1'b0;
      wb_seen = '0;
      for (int i = 0; i < 32768; i++) begin
         mem[i]     = 16'(i) * 16'h9E37 ^ 16'h5A5A;
         ref_mem[i] = 16'(i) * 16'h9E37 ^ 16'h5A5A;
      end
      mem[8] = 16'hBEEF;
      ref_mem[8] = 16'hBEEF;
      for (int i = 0; i < 256; i++) begin
         ref_val[i] = 1'b0;
         ref_dir[i] = 1'b0;
         ref_tag[i] = '0;
      end
      #3;
      chk1("reset_stall", Stall, 1'b0);
      chk1("reset_done", Done, 1'b0);
      chk1("reset_err", err, 1'b0);
      chk1("reset_cen", c_enable, 1'b0);
      chk1("reset_mrd", m_rd, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      access(1'b0, 16'h0010, 16'h0000, 0, 0, -1, lat);
      chk_int("cold_load_latency", lat, 7);
      chk16("cold_load_beef", DataOut, 16'hBEEF);
      access(1'b0, 16'h0010, 16'h0000, 0, 0, -1, lat);
      chk_int("hit_latency", lat, 0);
      access(1'b1, 16'h0012, 16'h1234, 0, 0, -1, lat);
      access(1'b0, 16'h0812, 16'h0000, 0, 0, -1, lat);
      chk_int("dirty_miss_latency", lat, 11);
      chk16("writeback_1234", wb_seen, 16'h1234);
      access(1'b0, 16'h0010, 16'h0000, 0, 0, -1, lat);
      access(1'b0, 16'h1020, 16'h0000, 1, 3, -1, lat);
      chk_int("stalled_fill_latency", lat, 10);
      for (int j = 0; j < 4; j++) begin
         access(1'b0, 16'h1020 + 16'(2 * j), 16'h0000, 0, 0, -1, lat);
         chk_int("stalled_fill_word_hit", lat, 0);
      end
      access(1'b1, 16'h1024, 16'hCAFE, 0, 0, -1, lat);
      access(1'b0, 16'h2024, 16'h0000, 2, 2, -1, lat);
      chk_int("stalled_wb_latency", lat, 13);
      access(1'b0, 16'h1024, 16'h0000, 0, 0, -1, lat);
      chk16("cafe_roundtrip", DataOut, 16'hCAFE);
      access(1'b1, 16'h00A8, 16'h7777, 0, 0, -1, lat);
      chk_int("store_miss_latency", lat, 7);
      access(1'b0, 16'h00A8, 16'h0000, 0, 0, -1, lat);
      chk16("store_miss_data", DataOut, 16'h7777);

      bad_req("rdwr", 1'b1, 1'b1, 16'h0010);
      bad_req("misalign_ld", 1'b1, 1'b0, 16'h0011);
      bad_req("misalign_st", 1'b0, 1'b1, 16'h0013);

      @(posedge clk);
      #1;
      Rd = 1'b0; Wr = 1'b0; Addr = 16'h0010;
      @(negedge clk);
      chk1("idle_cen", c_enable, 1'b0);
      chk1("idle_mrd", m_rd, 1'b0);
      chk1("idle_mwr", m_wr, 1'b0);
      chk1("idle_done", Done, 1'b0);

      access(1'b0, 16'h0040, 16'h0000, 0, 0, 5, lat);
      repeat (2) @(posedge clk);
      #1;
      Rd = 1'b0; Wr = 1'b0;
      for (int i = 0; i < 256; i++) ref_val[i] = 1'b0;
      rst = 1'b1;
      access(1'b0, 16'h0040, 16'h0000, 0, 0, -1, lat);
      chk_int("post_reset_miss_latency", lat, 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped data-cache controller between the pipeline memory stage and a 4-bank main memory.
- Serves 16-bit word loads/stores from the memory stage.
- Drives an external cache array (tag/valid/dirty/data, 256 lines x 4 words) and the banked memory.
- Asserts Stall to freeze the pipeline on a miss.
- Handles dirty-victim writeback and 4-word line fill.

Parameters:
MEM_LAT, 2, cycles from memory read request to mem_data_out valid (only 2 is supported).
ERR_ON_MISALIGN, 1, when 1, an odd address raises err and suppresses the access.

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
Rd  input  1  load request from memory stage
Wr  input  1  store request from memory stage
Addr  input  16  byte address: tag=[15:11], index=[10:3], offset=[2:0], word=[2:1]
DataIn  input  16  store data
DataOut  output  16  load data, valid when Done=1
Done  output  1  one-cycle pulse: request completed
Stall  output  1  controller busy; pipeline must hold
CacheHit  output  1  with Done: completed in compare cycle without a miss
err  output  1  illegal request (Rd&Wr, or misaligned address)
c_enable, c_comp, c_write, c_valid_in  output  1 each  cache array controls
c_index  output  8  cache line index
c_offset  output  3  cache word offset
c_tag_in  output  5  cache tag write value
c_data_in  output  16  cache write data
c_hit, c_dirty, c_valid  input  1 each  cache compare/victim status
c_tag_out  input  5  victim tag
c_data_out  input  16  cache read data
m_addr  output  16  memory address
m_data_in  output  16  memory write data
m_wr, m_rd  output  1 each  memory request strobes
m_data_out  input  16  memory read data
m_stall  input  1  memory cannot accept a request this cycle (bank busy)

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; latched request cleared.
- States: IDLE, WB0-WB3, RD0-RD3, WT0, WT1, ACC.
- IDLE with Rd^Wr, legal address:
  - Drive c_enable=1, c_comp=1, c_write=Wr, index/offset/tag from Addr, c_data_in=DataIn.
  - c_hit & c_valid: Done=1, CacheHit=1, DataOut=c_data_out, Stall=0; stay IDLE.
  - Otherwise latch Addr, DataIn, Wr. Next state is WB0 if (c_valid & c_dirty), else RD0.
- Stall=1 in every state other than IDLE. Rd/Wr/Addr/DataIn are ignored while Stall=1.
- WBk (k=0..3):
  - Read cache word k with c_comp=0, c_write=0.
  - m_wr=1, m_addr={c_tag_out, index, k, 1'b0}, m_data_in=c_data_out.
  - WB3 goes to RD0.
- RDk: m_rd=1, m_addr={latched tag, index, k, 1'b0}. RD3 goes to WT0; WT0 goes to WT1.
- Fill:
  - Data for the request issued in cycle n is written in cycle n+2 (RD2, RD3, WT0, WT1 write words 0..3).
  - Writes use c_comp=0, c_write=1, c_tag_in=latched tag, c_data_in=m_data_out.
  - c_valid_in=1 on the fill writes.
- ACC:
  - Replay the latched access with c_comp=1.
  - A store writes DataIn and sets dirty; a load returns DataOut=c_data_out.
  - Done=1, CacheHit=0; go to IDLE.
- m_stall=1 in any WB/RD state: no strobe issued; state held; the same request is retried next cycle.
  - Outstanding returns still complete on schedule. The fill offset is tracked by a return counter, not by state.
- Latency, counting the request cycle as 0:
  - hit: Done in cycle 0
  - clean miss: Done in cycle 7
  - dirty miss: Done in cycle 11
  - each m_stall cycle adds 1.
- err:
  - Raised combinationally in IDLE for Rd&Wr, or for odd Addr[0] when ERR_ON_MISALIGN=1.
  - No cache or memory access is made and Done stays 0.
  - err is 0 in all other states.
- Reset mid-miss: return to IDLE immediately. The line is left with whatever words were written and valid_in=0 was never issued. Software must treat that line as undefined.
- Rd=Wr=0 in IDLE: no activity; all strobes 0.

Test Plan:
- Cold load Addr=0x0010 (memory word=0xBEEF) -> m_rd at offsets 0,2,4,6 in cycles 1-4; Done=1, CacheHit=0, DataOut=0xBEEF in cycle 7.
- Repeat load 0x0010 -> Done=1, CacheHit=1, Stall=0 in cycle 0.
- Store 0x1234 to 0x0012 (hit), then load 0x0812 (same index, different tag) -> m_wr in cycles 1-4 with addresses 0x0010-0x0016 and 0x1234 at 0x0012; then fill; Done in cycle 11.
- m_stall=1 during RD1 for 3 cycles -> RD1 reissued after stall drops; Done in cycle 10; all 4 fill words correct.
- Rd=Wr=1, or load at 0x0011 -> err=1 same cycle; no m_rd/m_wr/c_enable; Done=0.
- rst=0 during WT0 -> all outputs 0 immediately; state IDLE; next load to the same line is serviced as a miss.
